// File: rtl/pclk_monitor.sv
// pclk_monitor: measures the returned camera pixel clock (clk_in) in the
// clk_50 domain. Rising edges are counted over a fixed gate window and
// reported once per window; a clock-present flag drops after a run of
// cycles with no detected edge.
// Optional macro RANGE_CHECK_EN: registers an in_range flag from each new
// count (inclusive MIN_COUNT..MAX_COUNT); when undefined in_range is tied 0.
//
// state   | meaning
// --------+--------------------------------------------------
// ST_IDLE | no recent edge, clk_present=0
// ST_RUN  | edges arriving, clk_present=1 until idle timeout

module pclk_monitor #(
   parameter int GATE_CYCLES    = 50000,
   parameter int CNT_W          = 16,
   parameter int TIMEOUT_CYCLES = 256,
   parameter int MIN_COUNT      = 11000,
   parameter int MAX_COUNT      = 14000
) (
   input  logic             clk_50,
   input  logic             rst,
   input  logic             clk_in,
   output logic [CNT_W-1:0] freq_count,
   output logic             freq_valid,
   output logic             clk_present,
   output logic             in_range
);

   localparam int GW = $clog2(GATE_CYCLES);
   localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
   localparam logic [IW-1:0]    IDLE_MAX  = IW'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

   state_t           state_q, state_d;
   logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
   logic [GW-1:0]    gate_q, gate_d;
   logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
   logic [IW-1:0]    idle_q, idle_d;
   logic [CNT_W-1:0] freq_count_q, freq_count_d;
   logic             freq_valid_q, freq_valid_d;
   logic             in_range_q, in_range_d;

   logic             edge_det;
   logic             terminal;
   logic [CNT_W-1:0] cnt_inc;

   // Synchronizer, gate/edge/idle counters and result registers next-state.
   always_comb begin
      s1_d = clk_in;
      s2_d = s1_q;
      s3_d = s2_q;

      edge_det = s2_q & ~s3_q;
      terminal = (gate_q == GATE_LAST);

      // An edge on the terminal cycle still belongs to the closing window.
      cnt_inc = (edge_det && edge_cnt_q != CNT_MAX) ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;

      gate_d       = terminal ? '0 : gate_q + GW'(1);
      edge_cnt_d   = terminal ? '0 : cnt_inc;
      freq_count_d = terminal ? cnt_inc : freq_count_q;
      freq_valid_d = terminal;

      if (edge_det)
         idle_d = '0;
      else if (idle_q == IDLE_MAX)
         idle_d = idle_q;
      else
         idle_d = idle_q + IW'(1);

`ifdef RANGE_CHECK_EN
      in_range_d = terminal ? ((cnt_inc >= CNT_W'(MIN_COUNT)) && (cnt_inc <= CNT_W'(MAX_COUNT)))
                            : in_range_q;
`else
      in_range_d = 1'b0;
`endif
   end

   // Control FSM next state: an edge always wins over the idle timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (edge_det) state_d = ST_RUN;
         ST_RUN:  if (!edge_det && idle_d == IDLE_MAX) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Control FSM outputs.
   always_comb begin
      clk_present = (state_q == ST_RUN);
   end

   // All state registers; synchronous reset has priority.
   always_ff @(posedge clk_50) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         s1_q         <= 1'b0;
         s2_q         <= 1'b0;
         s3_q         <= 1'b0;
         gate_q       <= '0;
         edge_cnt_q   <= '0;
         idle_q       <= '0;
         freq_count_q <= '0;
         freq_valid_q <= 1'b0;
         in_range_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         s1_q         <= s1_d;
         s2_q         <= s2_d;
         s3_q         <= s3_d;
         gate_q       <= gate_d;
         edge_cnt_q   <= edge_cnt_d;
         idle_q       <= idle_d;
         freq_count_q <= freq_count_d;
         freq_valid_q <= freq_valid_d;
         in_range_q   <= in_range_d;
      end
   end

   assign freq_count = freq_count_q;
   assign freq_valid = freq_valid_q;
   assign in_range   = in_range_q;

endmodule

// File: tb/tb_pclk_monitor.sv
// Bench for pclk_monitor: clk_in is driven on clk_50 negedges with directed
// and randomized patterns; a timestamp model assigns each rising edge to a
// window and tracks time since the last edge.
module tb_pclk_monitor;

   localparam int G    = 1000;
   localparam int CW   = 8;
   localparam int T    = 256;
   localparam int MINC = 240;
   localparam int MAXC = 260;
   localparam int NWIN = 64;

   logic          clk_50 = 1'b0;
   logic          rst    = 1'b1;
   logic          clk_in = 1'b0;
   logic [CW-1:0] freq_count;
   logic          freq_valid;
   logic          clk_present;
   logic          in_range;

   pclk_monitor #(
      .GATE_CYCLES   (G),
      .CNT_W         (CW),
      .TIMEOUT_CYCLES(T),
      .MIN_COUNT     (MINC),
      .MAX_COUNT     (MAXC)
   ) dut (
      .clk_50     (clk_50),
      .rst        (rst),
      .clk_in     (clk_in),
      .freq_count (freq_count),
      .freq_valid (freq_valid),
      .clk_present(clk_present),
      .in_range   (in_range)
   );

   always #10 clk_50 = ~clk_50;

   int checks = 0;
   int errors = 0;

   // Model state: k = clk_50 cycles since the last reset-sampling edge.
   int k = 0;
   bit prev_lvl = 1'b0;
   int win_cnt [NWIN];
   int edge_q[$];
   int last_e = 0;
   bit have_e = 1'b0;
   int exp_cnt = 0;
   bit exp_inr = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s k=%0d got %0d exp %0d", tag, k, got, exp);
      end
   endtask

   task automatic model_reset();
      k = 0;
      prev_lvl = 1'b0;
      for (int i = 0; i < NWIN; i++) win_cnt[i] = 0;
      edge_q.delete();
      have_e = 1'b0;
      last_e = 0;
      exp_cnt = 0;
      exp_inr = 1'b0;
   endtask

   task automatic check_now();
      bit vexp;
      bit pexp;
      int w;
      int n;
      vexp = (k > 0) && (k % G == 0);
      if (vexp) begin
         w = k / G - 1;
         n = (w < NWIN) ? win_cnt[w] : 0;
         exp_cnt = (n > (1 << CW) - 1) ? (1 << CW) - 1 : n;
         exp_inr = (exp_cnt >= MINC) && (exp_cnt <= MAXC);
      end
      while (edge_q.size() > 0 && edge_q[0] < k) begin
         last_e = edge_q.pop_front();
         have_e = 1'b1;
      end
      pexp = have_e && ((k - last_e) <= T);
      chk("freq_valid", 32'(freq_valid), 32'(vexp));
      chk("freq_count", 32'(freq_count), exp_cnt);
      chk("clk_present", 32'(clk_present), 32'(pexp));
`ifdef RANGE_CHECK_EN
      chk("in_range", 32'(in_range), 32'(exp_inr));
`else
      chk("in_range", 32'(in_range), 0);
`endif
   endtask

   // One clk_50 cycle: set clk_in level for the next sample, then check.
   task automatic step(input logic v);
      int e;
      @(negedge clk_50);
      rst = 1'b0;
      clk_in = v;
      if (v && !prev_lvl) begin
         // sampled by s1 at cycle k+1, seen as an edge during cycle k+2
         e = k + 2;
         edge_q.push_back(e);
         if (e / G < NWIN) win_cnt[e / G]++;
      end
      prev_lvl = v;
      @(posedge clk_50);
      #1;
      k++;
      check_now();
   endtask

   task automatic do_reset(input int n);
      @(negedge clk_50);
      rst = 1'b1;
      repeat (n) @(posedge clk_50);
      #1;
      model_reset();
      check_now();
   endtask

   task automatic run_div(input int period, input int hi, input int ncyc);
      int ph;
      ph = int'($urandom_range(0, period - 1));
      for (int i = 0; i < ncyc; i++) step(((i + ph) % period) < hi);
   endtask

   task automatic run_low(input int ncyc);
      for (int i = 0; i < ncyc; i++) step(1'b0);
   endtask

   initial begin
      int p;
      int h;
      int ph;
      int i;

      do_reset(3);
      run_low(20);

      // 12.5 MHz: ~250 per window, in range
      run_div(4, 2, 3000);
      // 25 MHz: 500 per window, saturates at 255
      run_div(2, 1, 2000);
      // 6.25 MHz: 125 per window, out of range
      run_div(8, 4, 1500);
      // clock loss: partial window, then a zero window
      run_low(2200);

      // single edge landing exactly on the terminal gate cycle
      while (k % G != G - 3) step(1'b0);
      step(1'b1);
      step(1'b1);
      run_low(1100);

      // randomized periods and duty cycles
      repeat (3) begin
         p = int'($urandom_range(2, 12));
         h = int'($urandom_range(1, p - 1));
         run_div(p, h, int'($urandom_range(300, 900)));
      end

      // reset in the middle of a window at gate=600
      ph = int'($urandom_range(0, 3));
      i = 0;
      while (k % G != 600) begin
         step(((i + ph) % 4) < 2);
         i++;
      end
      do_reset(1);
      run_div(4, 2, 1100);
      run_low(300);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pclk_monitor.md
Name: pclk_monitor

Overview:
- Measures the camera's returned pixel clock (OV7670 PCLK, driven from the XCLK that clockdiv sources) in the clk_50 domain; this is the receiving end of the clock interface.
- Counts rising edges of the asynchronous clk_in over a fixed gate window and reports the count once per window.
- Flags loss of clock after a timeout, giving bring-up/status logic a frequency readout and a clock-present indication.

Parameters:
- GATE_CYCLES, 50000, gate window length in clk_50 cycles (1 ms at 50 MHz); must be ≥ 2
- CNT_W, 16, width of edge counter and freq_count
- TIMEOUT_CYCLES, 256, clk_50 cycles with no detected edge before clk_present drops; must be ≥ 2
- MIN_COUNT, 11000, lower in-range bound (only with RANGE_CHECK_EN)
- MAX_COUNT, 14000, upper in-range bound (only with RANGE_CHECK_EN)

Ports:
- clk_50  input  1  master clock, 50 MHz
- rst  input  1  synchronous reset, active-high
- clk_in  input  1  monitored clock, asynchronous to clk_50, frequency < 25 MHz
- freq_count  output  CNT_W  rising edges counted in last completed window, saturating
- freq_valid  output  1  one-cycle pulse when freq_count updates
- clk_present  output  1  high while edges are arriving
- in_range  output  1  MIN_COUNT ≤ freq_count ≤ MAX_COUNT (RANGE_CHECK_EN only; else tied 0)

Behaviour:
- All state is clocked on posedge clk_50; rst is sampled synchronously and takes priority over everything else.
- Reset values: freq_count=0, freq_valid=0, clk_present=0, in_range=0, sync/history FFs=0, gate counter=0, edge counter=0, idle counter=0.
- Synchronizer: clk_in passes through 2 FFs (s1, s2), plus a history FF s3.
  - edge = s2 & ~s3.
  - A rising edge on clk_in is seen as edge 2–3 cycles later. Latency is fixed by the FF chain.
- Gate counter:
  - Runs 0..GATE_CYCLES-1 and wraps to 0.
  - The terminal cycle is gate==GATE_CYCLES-1.
- Edge counter:
  - Increments on edge and saturates at 2^CNT_W-1 (no wrap).
  - On the terminal cycle: freq_count <= sat(edge_cnt + edge), freq_valid <= 1 the following cycle only, edge_cnt <= 0.
  - An edge on the terminal cycle belongs to the closing window.
- First window after reset is a full GATE_CYCLES long. freq_valid first pulses GATE_CYCLES cycles after rst deasserts; no earlier pulse.
- Idle counter:
  - Cleared on edge; otherwise increments, saturating at TIMEOUT_CYCLES.
  - clk_present <= 1 on any edge.
  - clk_present <= 0 when the idle counter reaches TIMEOUT_CYCLES (i.e. TIMEOUT_CYCLES cycles after the last edge).
  - edge and timeout cannot coincide, since an edge clears the counter and wins.
- Control state machine, 2 states:
  - IDLE (clk_present=0) → RUN on edge.
  - RUN → IDLE on timeout.
  - RUN → RUN on edge or while counting.
  - Measurement windows run in both states. A dead clock reports freq_count=0 after one full window.
- Reset mid-window: the window is discarded, no freq_valid, gate counter restarts from 0.
- freq_count holds its value between windows; it is never cleared except by rst.

Optional Feature:
- Macro RANGE_CHECK_EN.
  - Defined: in_range is registered and updated in the same cycle as freq_count, from the new count, using inclusive bounds. It is reset to 0.
  - Undefined: in_range is constant 0 and no comparator logic is built.

Test Plan:
- GATE_CYCLES=1000, clk_in = clk_50/4 (12.5 MHz, rising edges every 4 cycles) → freq_valid pulses every 1000 cycles; freq_count=250 (±1 across phase); clk_present=1 within 3 cycles of the first clk_in edge.
- GATE_CYCLES=1000, CNT_W=8, clk_in = clk_50/2 (edge every 2 cycles, 500/window) → freq_count=255 (saturated), no wrap.
- Clock loss: TIMEOUT_CYCLES=256, stop clk_in low → clk_present falls 256–259 cycles after the last clk_in rising edge; the next window reports freq_count equal to the partial-window edges, and the one after reports 0. Restart clk_in → clk_present=1 within 3 cycles.
- Reset mid-window: assert rst for 1 cycle at gate=600 → all outputs 0 next cycle; the next freq_valid occurs exactly 1000 cycles after rst deasserts.
- RANGE_CHECK_EN, GATE_CYCLES=1000, MIN_COUNT=240, MAX_COUNT=260: clk_50/4 → in_range=1; clk_50/8 (count 125) → in_range=0 with the next freq_valid.
- Terminal-cycle edge: force an s2 rising edge exactly on gate=GATE_CYCLES-1 → it is counted in the closing window's freq_count, and the next window starts from 0.
